// File: rtl/bcd_digit_formatter_if.sv
// ---------------------------------------------------------------------------
// bcd_digit_formatter_if
//
// Purpose: groups the value/decimal-point handshake and the formatted digit
// outputs of bcd_digit_formatter into one bundle.
//
// Signals:
//   in_valid  value/dp_mask are offered this cycle
//   in_ready  formatter is idle and can accept a value
//   value     unsigned binary number to display (INPUT_WIDTH bits)
//   dp_mask   per-digit decimal point, bit k applies to digits[k]
//   digits    four 6-bit codes {lit, dp, nibble}; digits[0] is leftmost
//   done      one-cycle pulse when digits update
//   overflow  high while the displayed value is saturated
//
// Modports:
//   master  producer of values / consumer of digits (e.g. a testbench)
//   slave   the formatter itself
// ---------------------------------------------------------------------------
interface bcd_digit_formatter_if #(
  parameter int INPUT_WIDTH = 14
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INPUT_WIDTH-1:0] value;
  logic [3:0]             dp_mask;
  // Index 0 occupies the most significant bits, so a 24-bit literal such as
  // {6'h21, 6'h22, 6'h23, 6'h24} reads left to right like the display.
  logic [0:3][5:0]        digits;
  logic                   done;
  logic                   overflow;

  modport master (
    output in_valid,
    output value,
    output dp_mask,
    input  in_ready,
    input  digits,
    input  done,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  value,
    input  dp_mask,
    output in_ready,
    output digits,
    output done,
    output overflow
  );
endinterface

// File: rtl/bcd_digit_formatter.sv
// ---------------------------------------------------------------------------
// bcd_digit_formatter
//
// Purpose: iterative binary-to-BCD converter (shift-and-add-3, one input bit
// per clock) that produces four display digit codes for a downstream
// seven-segment driver. Applies leading-zero blanking and saturates values
// above 9999 to "9999" with the overflow flag raised.
//
// Parameters:
//   INPUT_WIDTH          width of the binary value (>= 14 so 9999 fits)
//   BLANK_LEADING_ZEROS  1 = blank leading zero digits, 0 = show all four
//
// Ports:
//   clock  system clock, everything on the rising edge
//   reset  synchronous active-high reset; aborts any conversion in flight
//   bus    bcd_digit_formatter_if.slave:
//            in_valid/in_ready/value/dp_mask  input handshake
//            digits/done/overflow             formatted result
//
// Timing: a value accepted in cycle C shows its digits, done = 1 and
// in_ready = 1 in cycle C + INPUT_WIDTH + 2.
// ---------------------------------------------------------------------------
module bcd_digit_formatter #(
  parameter int INPUT_WIDTH         = 14,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  bcd_digit_formatter_if.slave bus
);

  localparam int CNT_W       = $clog2(INPUT_WIDTH + 1);
  localparam int MAX_DISPLAY = 9999;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(INPUT_WIDTH - 1);

  // Narrower inputs cannot represent the full display range.
  if (INPUT_WIDTH < 14) begin : g_width_check
    $error("bcd_digit_formatter: INPUT_WIDTH must be >= 14");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // One-cycle strobes decoded from the state machine.
  logic load;
  logic step;
  logic finish;

  // Conversion datapath.
  logic [INPUT_WIDTH-1:0] bin_reg;     // remaining binary bits, MSB first
  logic [15:0]            bcd_reg;     // four BCD nibbles, thousands on top
  logic [15:0]            bcd_adj;     // bcd_reg after the add-3 correction
  logic [CNT_W-1:0]       count_reg;   // shift steps taken so far
  logic [3:0]             dp_reg;      // latched decimal-point mask
  logic                   sat_reg;     // latched value exceeded 9999

  // Result registers.
  logic [0:3][5:0]        digits_reg;
  logic [0:3][5:0]        fmt;
  logic                   done_reg;
  logic                   overflow_reg;

  // Formatting scratch.
  logic                   scanning;
  logic [3:0]             nib;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and strobes
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        step = 1'b1;
        // The step taken with count == INPUT_WIDTH-1 consumes the last bit.
        if (count_reg == LAST_STEP) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Add-3 correction: any nibble >= 5 would become >= 10 after the coming
  // left shift, so bump it by 3 now to carry into the next decade instead.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                              ? bcd_reg[gi*4 +: 4] + 4'd3
                              : bcd_reg[gi*4 +: 4];
  end

  // -------------------------------------------------------------------------
  // Digit formatting from the finished accumulator.
  // Blanking walks left to right and stops at the first digit that has
  // either a nonzero nibble or its decimal point set; the units digit is
  // always lit so zero still shows as "0".
  // -------------------------------------------------------------------------
  always_comb begin
    fmt      = '0;
    nib      = 4'd0;
    scanning = BLANK_LEADING_ZEROS;
    for (int k = 0; k < 4; k++) begin
      nib = bcd_reg[(3 - k) * 4 +: 4];
      if (sat_reg) begin
        fmt[k] = {1'b1, dp_reg[k], 4'd9};
      end else if (scanning && (k < 3) && (nib == 4'd0) && !dp_reg[k]) begin
        fmt[k] = 6'h00;
      end else begin
        fmt[k]   = {1'b1, dp_reg[k], nib};
        scanning = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Datapath and result registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_reg      <= '0;
      bcd_reg      <= '0;
      count_reg    <= '0;
      dp_reg       <= '0;
      sat_reg      <= 1'b0;
      digits_reg   <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (load) begin
        bin_reg   <= bus.value;
        dp_reg    <= bus.dp_mask;
        // Decided at acceptance because bin_reg is consumed by the shifting.
        sat_reg   <= (bus.value > INPUT_WIDTH'(MAX_DISPLAY));
        bcd_reg   <= '0;
        count_reg <= '0;
      end

      if (step) begin
        // Shift {bcd, bin} left by one; whatever leaves the top of the
        // 16-bit accumulator only matters for values that saturate anyway.
        bcd_reg   <= {bcd_adj[14:0], bin_reg[INPUT_WIDTH-1]};
        bin_reg   <= bin_reg << 1;
        count_reg <= count_reg + CNT_W'(1);
      end

      if (finish) begin
        digits_reg   <= fmt;
        overflow_reg <= sat_reg;
        done_reg     <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready = (state_reg == IDLE);
  assign bus.digits   = digits_reg;
  assign bus.done     = done_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_bcd_digit_formatter.sv
// ---------------------------------------------------------------------------
// tb_bcd_digit_formatter
//
// Two formatter instances share one stimulus stream: one with leading-zero
// blanking, one showing all four digits. Expected results are queued when a
// value is accepted and compared when done pulses.
// ---------------------------------------------------------------------------
module tb_bcd_digit_formatter;

  localparam int W       = 14;
  localparam int LATENCY = W + 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  bcd_digit_formatter_if #(.INPUT_WIDTH(W)) bus0 ();
  bcd_digit_formatter_if #(.INPUT_WIDTH(W)) bus1 ();

  assign bus1.in_valid = bus0.in_valid;
  assign bus1.value    = bus0.value;
  assign bus1.dp_mask  = bus0.dp_mask;

  bcd_digit_formatter #(
    .INPUT_WIDTH         (W),
    .BLANK_LEADING_ZEROS (1'b1)
  ) dut_blank (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  bcd_digit_formatter #(
    .INPUT_WIDTH         (W),
    .BLANK_LEADING_ZEROS (1'b0)
  ) dut_full (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] value;
    logic [3:0]   dp;
    logic [23:0]  exp_digits;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [23:0] d_blank;
    logic [23:0] d_full;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // All-digits reference: plain decimal division, saturating at 9999.
  function automatic logic [23:0] full_model(input int v, input logic [3:0] dp);
    logic [23:0] r;
    int rem;
    int d;
    r   = '0;
    rem = v;
    for (int k = 3; k >= 0; k--) begin
      d   = (v > 9999) ? 9 : rem % 10;
      rem = rem / 10;
      r[(3 - k) * 6 +: 6] = {1'b1, dp[k], 4'(d)};
    end
    return r;
  endfunction

  // Result monitor: every done pulse must match the oldest queued expectation
  // and arrive exactly LATENCY cycles after acceptance.
  always @(negedge clock) begin
    if (bus0.done || bus1.done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=%b/%b expected no pulse (cycle %0d)",
                 bus0.done, bus1.done, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_both", {31'd0, bus0.done & bus1.done}, 32'd1);
        check("done_cycle", cyc, mon_e.due);
        check("digits_blank", {8'd0, bus0.digits}, {8'd0, mon_e.d_blank});
        check("digits_full", {8'd0, bus1.digits}, {8'd0, mon_e.d_full});
        check("overflow", {31'd0, bus0.overflow}, {31'd0, mon_e.ovf});
        check("overflow_full", {31'd0, bus1.overflow}, {31'd0, mon_e.ovf});
        $display("txn %0d: cycle %0d digits=%h full=%h overflow=%b",
                 txn, cyc, bus0.digits, bus1.digits, bus0.overflow);
        txn++;
      end
    end
  end

  task automatic wait_ready();
    int guard = 0;
    while (!bus0.in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (!bus0.in_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic push_exp(input logic [W-1:0] v, input logic [3:0] dp,
                          input logic [23:0] exp_d, input logic exp_o);
    exp_t e;
    e.d_blank = exp_d;
    e.d_full  = full_model(int'(v), dp);
    e.ovf     = exp_o;
    e.due     = cyc + LATENCY;
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [W-1:0] v, input logic [3:0] dp,
                      input logic [23:0] exp_d, input logic exp_o);
    @(negedge clock);
    wait_ready();
    bus0.in_valid = 1'b1;
    bus0.value    = v;
    bus0.dp_mask  = dp;
    push_exp(v, dp, exp_d, exp_o);
    @(negedge clock);
    bus0.in_valid = 1'b0;
    bus0.value    = W'($urandom);
    bus0.dp_mask  = 4'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  vec_t vecs[11];
  logic [W-1:0] b2b_vals[3];
  logic [23:0]  b2b_exp[3];

  initial begin
    int accepted;
    int last_acc;
    int guard;

    vecs[0]  = '{14'd1234,  4'b0000, {6'h21, 6'h22, 6'h23, 6'h24}, 1'b0};
    vecs[1]  = '{14'd7,     4'b0000, {6'h00, 6'h00, 6'h00, 6'h27}, 1'b0};
    vecs[2]  = '{14'd0,     4'b0000, {6'h00, 6'h00, 6'h00, 6'h20}, 1'b0};
    vecs[3]  = '{14'd5,     4'b0010, {6'h00, 6'h30, 6'h20, 6'h25}, 1'b0};
    vecs[4]  = '{14'd12000, 4'b0000, {6'h29, 6'h29, 6'h29, 6'h29}, 1'b1};
    vecs[5]  = '{14'd42,    4'b0000, {6'h00, 6'h00, 6'h24, 6'h22}, 1'b0};
    vecs[6]  = '{14'd1005,  4'b1000, {6'h21, 6'h20, 6'h20, 6'h35}, 1'b0};
    vecs[7]  = '{14'd16383, 4'b0101, {6'h39, 6'h29, 6'h39, 6'h29}, 1'b1};
    vecs[8]  = '{14'd10000, 4'b0000, {6'h29, 6'h29, 6'h29, 6'h29}, 1'b1};
    vecs[9]  = '{14'd80,    4'b0001, {6'h30, 6'h20, 6'h28, 6'h20}, 1'b0};
    vecs[10] = '{14'd0,     4'b1111, {6'h30, 6'h30, 6'h30, 6'h30}, 1'b0};

    b2b_vals[0] = 14'd1;
    b2b_vals[1] = 14'd2;
    b2b_vals[2] = 14'd3;
    b2b_exp[0]  = {6'h00, 6'h00, 6'h00, 6'h21};
    b2b_exp[1]  = {6'h00, 6'h00, 6'h00, 6'h22};
    b2b_exp[2]  = {6'h00, 6'h00, 6'h00, 6'h23};

    bus0.in_valid = 1'b0;
    bus0.value    = '0;
    bus0.dp_mask  = '0;
    reset         = 1'b1;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    check("rst_digits", {8'd0, bus0.digits}, 32'd0);
    check("rst_digits_full", {8'd0, bus1.digits}, 32'd0);
    check("rst_done", {31'd0, bus0.done}, 32'd0);
    check("rst_overflow", {31'd0, bus0.overflow}, 32'd0);
    reset = 1'b0;

    // Table-driven conversions
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].value, vecs[i].dp, vecs[i].exp_digits, vecs[i].exp_ovf);
      drain();
      check("hold_digits", {8'd0, bus0.digits}, {8'd0, vecs[i].exp_digits});
    end

    // Reset in the middle of a conversion discards it.
    @(negedge clock);
    wait_ready();
    bus0.in_valid = 1'b1;
    bus0.value    = 14'd9999;
    bus0.dp_mask  = 4'b0000;
    @(negedge clock);
    bus0.in_valid = 1'b0;
    repeat (5) @(negedge clock);
    check("busy_in_ready", {31'd0, bus0.in_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_in_ready", {31'd0, bus0.in_ready}, 32'd1);
    check("abort_digits", {8'd0, bus0.digits}, 32'd0);
    check("abort_overflow", {31'd0, bus0.overflow}, 32'd0);
    repeat (2 * LATENCY) @(negedge clock);
    check("abort_digits_later", {8'd0, bus0.digits}, 32'd0);
    check("abort_digits_full", {8'd0, bus1.digits}, 32'd0);
    send(14'd9999, 4'b0000, {6'h29, 6'h29, 6'h29, 6'h29}, 1'b0);
    drain();

    // Back-to-back: in_valid held high, junk values while busy.
    accepted = 0;
    last_acc = -1;
    guard    = 0;
    @(negedge clock);
    bus0.in_valid = 1'b1;
    while (accepted < 3 && guard < 200) begin
      if (bus0.in_ready) begin
        bus0.value   = b2b_vals[accepted];
        bus0.dp_mask = 4'b0000;
        push_exp(b2b_vals[accepted], 4'b0000, b2b_exp[accepted], 1'b0);
        if (accepted > 0) check("b2b_spacing", cyc - last_acc, LATENCY);
        last_acc = cyc;
        accepted++;
      end else begin
        bus0.value   = W'($urandom);
        bus0.dp_mask = 4'($urandom);
      end
      @(negedge clock);
      guard++;
    end
    bus0.in_valid = 1'b0;
    if (accepted < 3) begin
      checks++;
      errors++;
      $display("FAIL b2b_accepts: got %0d expected 3", accepted);
    end
    drain();
    repeat (4) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_digit_formatter.md
Name: bcd_digit_formatter

Overview:
- Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Sits directly upstream of seven_segment_with_dp and drives its digits[0:3] input.
- Accepts an unsigned binary value plus a decimal-point mask over a valid/ready handshake.
- Produces four 6-bit digit codes with leading-zero blanking and overflow saturation.

Parameters:
- INPUT_WIDTH, 14, width of the binary input value. Must be >= 14 so that 9999 is representable.
- BLANK_LEADING_ZEROS, 1, 1 = blank leading zero digits; 0 = show all four digits.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  value/dp_mask are offered this cycle.
- in_ready  output  1  block is idle and can accept a value.
- value  input  INPUT_WIDTH  unsigned binary number to display.
- dp_mask  input  4  per-digit decimal point; bit k applies to digits[k].
- digits  output  6 x [0:3]  digit codes. Bit5 = digit lit, bit4 = dp, [3:0] = hex/BCD nibble. digits[0] is the most significant (leftmost) digit.
- done  output  1  one-cycle pulse when digits update.
- overflow  output  1  high while the displayed value was saturated.

Behaviour:
- Reset values: digits all 6'h00 (all dark); done = 0; overflow = 0; state = IDLE; in_ready = 1.
- Reset takes effect on any cycle, including mid-conversion. The in-flight conversion is discarded and digits are not updated.
- States and transitions:
  - IDLE: in_ready = 1. When in_valid is high, latch value and dp_mask, clear the 16-bit BCD accumulator and bit counter, then go to SHIFT.
  - SHIFT: lasts exactly INPUT_WIDTH cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one bit. MSB of value goes first.
  - FINISH: lasts one cycle. Format and register digits, register overflow, pulse done, then return to IDLE.
- Timing: handshake accepted in cycle C. New digits, done = 1, and in_ready = 1 are all visible in cycle C + INPUT_WIDTH + 2 (C+16 at default).
- in_ready = 0 in SHIFT and FINISH. in_valid is ignored while in_ready = 0. value and dp_mask may change freely after acceptance.
- Overflow: if the latched value > 9999, each digit = lit, nibble 9, dp from mask, and overflow = 1. Otherwise overflow = 0. Bits of the BCD accumulator above 16 are discarded.
- Digit formatting (non-overflow):
  - digits[k][3:0] = BCD nibble k.
  - digits[k][4] = dp_mask[k].
  - digits[k][5] = 1 unless blanked.
- Blanking rule (BLANK_LEADING_ZEROS = 1): scan k = 0..2 left to right. Blank digit k (code 6'h00, dp also cleared) only while the nibble is 0 and dp_mask[k] = 0. Scanning stops at the first nonzero nibble or set dp. digits[3] is never blanked.
- digits and overflow hold their values between conversions. done is high for exactly one cycle per completed conversion.
- Back-to-back: in_valid held high re-accepts in the first IDLE cycle. Throughput is one conversion per INPUT_WIDTH + 2 cycles.

Test Plan:
- Reset, then value=1234, dp_mask=0 -> at cycle C+16: digits = 6'h21, 6'h22, 6'h23, 6'h24; done pulses once; overflow = 0.
- value=7 then value=0 (dp_mask=0) -> first result 6'h00, 6'h00, 6'h00, 6'h27; second result 6'h00, 6'h00, 6'h00, 6'h20. With BLANK_LEADING_ZEROS=0, value=7 gives 6'h20, 6'h20, 6'h20, 6'h27.
- value=5, dp_mask=4'b0010 -> digits = 6'h00, 6'h30, 6'h20, 6'h25 (blanking stops at the dp digit).
- value=12000, dp_mask=0 -> digits = 6'h29, 6'h29, 6'h29, 6'h29; overflow = 1. Then value=42 -> overflow returns to 0.
- Start value=9999, then assert reset for one cycle during SHIFT -> digits stay 6'h00, no done pulse, in_ready = 1 on the cycle after reset. Next value=9999 -> 6'h29 x4, overflow = 0.
- in_valid held high with values 1, 2, 3 presented on successive accepts -> accepts spaced exactly 16 cycles apart; done pulses at C+16, C+32, C+48; value changes while in_ready = 0 have no effect.
